reg_file_wr_decode: RTL and testbench
=====================================

Name: reg_file_wr_decode

Overview:
- Write-side counterpart of the 5-bit destination-register select path: takes the selected 5-bit destination address and decodes it to one of 32 register write enables.
- Holds the 32-entry register file of the single-cycle datapath.
- Provides two asynchronous read ports for rs/rt and an optional same-cycle write-to-read bypass.
- Sits between the write-back result mux and the ALU operand inputs.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth is 2**ADDR_W = 32 entries.
- BYPASS, 1, 1 = a read of the address being written returns inWrData in the same cycle; 0 = the read returns the stored value.

Ports:
- inClk  input  1  system clock; all state updates on the rising edge.
- inReset  input  1  synchronous, active-high reset.
- inWrEn  input  1  RegWrite from control.
- inWrAddr  input  ADDR_W  destination register from the 5-bit select mux.
- inWrData  input  DATA_W  write-back data.
- inRdAddrA  input  ADDR_W  rs address.
- inRdAddrB  input  ADDR_W  rt address.
- outRdDataA  output  DATA_W  rs data, combinational.
- outRdDataB  output  DATA_W  rt data, combinational.
- outWrDec  output  2**ADDR_W  registered one-hot record of the last committed write, for debug and verification.
- outWrCount  output  16  count of committed writes, saturating.

Behaviour:
- Reset, synchronous: on a rising edge with inReset=1, all 32 registers go to 0, outWrDec goes to 0 and outWrCount goes to 0. Reset has priority over a simultaneous write, so the write is dropped.
- Decode: dec[i] = inWrEn & (inWrAddr == i), for i = 1..31. dec[0] is forced to 0.
- Write commit, on the rising edge when inReset=0:
  - if dec[i]=1, reg[i] <= inWrData;
  - a committed write requires inWrEn=1 and inWrAddr != 0.
- Register 0 is hardwired to zero: it is never written, and reads of address 0 always return 0 regardless of bypass.
- outWrDec: on each edge, outWrDec <= dec, so it is one-hot after a committed write and all-zero otherwise. Latency is 1 cycle after the write edge.
- outWrCount:
  - increments by 1 on each committed write;
  - saturates at 16'hFFFF and holds there;
  - writes to address 0 and cycles with inWrEn=0 do not count.
- Read ports: purely combinational from the addresses and register contents, with no clock latency.
- Bypass when BYPASS=1: if inWrEn=1, inWrAddr == rdAddr and rdAddr != 0, the read data is inWrData. Otherwise it is reg[rdAddr].
- Bypass when BYPASS=0: the read returns the old value until the edge, then the new value.
- Both read ports may address the same register, including the one being written; both return identical data.
- Back-to-back writes to the same address: the last write wins, one value per edge.
- Reset asserted mid-program: the register state is lost, all reads return 0 on the cycle after the reset edge, and the counter restarts at 0.
- X/unknown addresses are not required to be handled. The bench drives only known values.

Test Plan:
- Reset then read: assert inReset for 1 edge, deassert, read all addresses 0..31 on both ports -> every read is 0, outWrDec=0, outWrCount=0.
- Write/readback: write 32'hDEADBEEF to reg 5 and 32'h12345678 to reg 31, then read A=5, B=31 -> A=32'hDEADBEEF, B=32'h12345678. After the reg 31 write, outWrDec = 32'h80000000 and outWrCount=2.
- Register 0 protection: inWrEn=1, inWrAddr=0, data 32'hFFFFFFFF, then read A=0 -> 0. Both outWrDec and outWrCount are unchanged.
- Bypass, BYPASS=1: reg 7 holds 32'h1. In the same cycle, write 32'hA5A5A5A5 to reg 7 with A=B=7 -> both ports show 32'hA5A5A5A5 before the edge. With BYPASS=0, both ports show 32'h1 before the edge and 32'hA5A5A5A5 after it.
- Reset vs write collision: inReset=1 and a write of 32'h55 to reg 3 on the same edge -> reg 3 reads 0 and outWrCount=0.
- Counter saturation: perform 65540 writes to reg 2 -> outWrCount holds at 16'hFFFF, and reg 2 holds the last data written.

Source files
------------

// File: rtl/reg_file_wr_decode.sv
// 32-entry register file with one-hot write decode, two combinational read
// ports with optional write-to-read bypass, and a saturating commit counter.
module reg_file_wr_decode #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic                   inClk,
  input  logic                   inReset,
  input  logic                   inWrEn,
  input  logic [ADDR_W-1:0]      inWrAddr,
  input  logic [DATA_W-1:0]      inWrData,
  input  logic [ADDR_W-1:0]      inRdAddrA,
  input  logic [ADDR_W-1:0]      inRdAddrB,
  output logic [DATA_W-1:0]      outRdDataA,
  output logic [DATA_W-1:0]      outRdDataB,
  output logic [(1<<ADDR_W)-1:0] outWrDec,
  output logic [15:0]            outWrCount
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0]             dec;
  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [1:0][ADDR_W-1:0]       rd_addr;
  logic [1:0][DATA_W-1:0]       rd_data;

  // Entry 0 never decodes, so writes to it commit nothing and are not counted.
  always_comb begin
    dec = '0;
    for (int i = 1; i < DEPTH; i++)
      dec[i] = inWrEn && (inWrAddr == ADDR_W'(i));
  end

  always_ff @(posedge inClk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (inReset || i == 0) regs[i] <= '0;
      else if (dec[i])       regs[i] <= inWrData;
    end
  end

  always_ff @(posedge inClk) begin
    if (inReset) begin
      outWrDec   <= '0;
      outWrCount <= '0;
    end else begin
      outWrDec <= dec;
      if (|dec && outWrCount != 16'hFFFF) outWrCount <= outWrCount + 16'd1;
    end
  end

  assign rd_addr[0] = inRdAddrA;
  assign rd_addr[1] = inRdAddrB;

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < 2; p++) begin
      if (rd_addr[p] == '0)
        rd_data[p] = '0;
      else if (BYPASS && inWrEn && inWrAddr == rd_addr[p])
        rd_data[p] = inWrData;
      else
        rd_data[p] = regs[rd_addr[p]];
    end
  end

  assign outRdDataA = rd_data[0];
  assign outRdDataB = rd_data[1];
endmodule

// File: tb/tb_reg_file_wr_decode.sv
// Scoreboard bench: stimulus pushes expected outputs for both bypass variants,
// a negedge monitor pops and compares against the live DUT outputs.
module tb_reg_file_wr_decode;
  logic        inClk = 1'b0;
  logic        inReset = 1'b0;
  logic        inWrEn = 1'b0;
  logic [4:0]  inWrAddr = '0;
  logic [31:0] inWrData = '0;
  logic [4:0]  inRdAddrA = '0;
  logic [4:0]  inRdAddrB = '0;
  logic [31:0] a1, b1, a0, b0, dec1, dec0;
  logic [15:0] cnt1, cnt0;

  int nchk = 0;
  int nfail = 0;

  typedef struct {
    string       name;
    logic [31:0] a1, b1, a0, b0, dec;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];

  always #5 inClk = ~inClk;

  reg_file_wr_decode #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_bp (
    .inClk(inClk), .inReset(inReset), .inWrEn(inWrEn), .inWrAddr(inWrAddr),
    .inWrData(inWrData), .inRdAddrA(inRdAddrA), .inRdAddrB(inRdAddrB),
    .outRdDataA(a1), .outRdDataB(b1), .outWrDec(dec1), .outWrCount(cnt1));

  reg_file_wr_decode #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
    .inClk(inClk), .inReset(inReset), .inWrEn(inWrEn), .inWrAddr(inWrAddr),
    .inWrData(inWrData), .inRdAddrA(inRdAddrA), .inRdAddrB(inRdAddrB),
    .outRdDataA(a0), .outRdDataB(b0), .outWrDec(dec0), .outWrCount(cnt0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare at the falling edge.
  always @(negedge inClk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, ".bp.a"},   a1,           e.a1);
      chk({e.name, ".bp.b"},   b1,           e.b1);
      chk({e.name, ".nb.a"},   a0,           e.a0);
      chk({e.name, ".nb.b"},   b0,           e.b0);
      chk({e.name, ".bp.dec"}, dec1,         e.dec);
      chk({e.name, ".nb.dec"}, dec0,         e.dec);
      chk({e.name, ".bp.cnt"}, {16'h0, cnt1}, {16'h0, e.cnt});
      chk({e.name, ".nb.cnt"}, {16'h0, cnt0}, {16'h0, e.cnt});
    end
  end

  task automatic cyc(input logic rst, input logic en, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
    @(posedge inClk);
    #1;
    inReset = rst; inWrEn = en; inWrAddr = wa; inWrData = wd;
    inRdAddrA = ra; inRdAddrB = rb;
  endtask

  task automatic expect_rd(input string nm, input logic [31:0] ea1, input logic [31:0] eb1,
                           input logic [31:0] ea0, input logic [31:0] eb0,
                           input logic [31:0] ed, input logic [15:0] ec);
    exp_t e;
    e.name = nm; e.a1 = ea1; e.b1 = eb1; e.a0 = ea0; e.b0 = eb0; e.dec = ed; e.cnt = ec;
    sb.push_back(e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then every address on both ports reads zero.
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 0, 0, 5'(i), 5'(31 - i));
      expect_rd("rst_read", 0, 0, 0, 0, 0, 0);
    end

    // Write/readback.
    cyc(0, 1, 5, 32'hDEADBEEF, 0, 0);
    expect_rd("wr5", 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 31, 32'h12345678, 5, 5);
    expect_rd("wr31", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000020, 1);
    // Register 0 write: not committed, dec/count keep the reg 31 record for this cycle.
    cyc(0, 1, 0, 32'hFFFFFFFF, 0, 31);
    expect_rd("wr0", 0, 32'h12345678, 0, 32'h12345678, 32'h80000000, 2);
    cyc(0, 0, 0, 0, 5, 31);
    expect_rd("rdback", 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 0, 2);
    cyc(0, 0, 0, 0, 0, 0);
    expect_rd("rd0", 0, 0, 0, 0, 0, 2);

    // Bypass: reg 7 = 1, then overwrite with A5A5A5A5 while reading it on both ports.
    cyc(0, 1, 7, 32'h1, 7, 7);
    expect_rd("bp_init", 32'h1, 32'h1, 0, 0, 0, 2);
    cyc(0, 1, 7, 32'hA5A5A5A5, 7, 7);
    expect_rd("bp_same", 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1, 32'h1, 32'h00000080, 3);
    cyc(0, 0, 0, 0, 7, 7);
    expect_rd("bp_after", 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000080, 4);

    // Back-to-back writes to reg 9: last wins.
    cyc(0, 1, 9, 32'h11, 9, 5);
    expect_rd("b2b_1", 32'h11, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 4);
    cyc(0, 1, 9, 32'h22, 9, 9);
    expect_rd("b2b_2", 32'h22, 32'h22, 32'h11, 32'h11, 32'h00000200, 5);
    cyc(0, 0, 0, 0, 9, 7);
    expect_rd("b2b_3", 32'h22, 32'hA5A5A5A5, 32'h22, 32'hA5A5A5A5, 32'h00000200, 6);

    // Reset colliding with a write to reg 3: write dropped, state cleared.
    cyc(1, 1, 3, 32'h55, 0, 0);
    expect_rd("rst_col", 0, 0, 0, 0, 0, 6);
    cyc(0, 0, 0, 0, 3, 9);
    expect_rd("rst_after", 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 7, 5);
    expect_rd("rst_after2", 0, 0, 0, 0, 0, 0);

    // Saturation: 65540 writes of (3*i+1) to reg 2.
    for (int i = 0; i < 65540; i++) begin
      cyc(0, 1, 2, 32'(i) * 32'd3 + 32'd1, 0, 0);
      if (i == 65535) expect_rd("sat_reach", 0, 0, 0, 0, 32'h4, 16'hFFFF);
      if (i == 65537) expect_rd("sat_hold", 0, 0, 0, 0, 32'h4, 16'hFFFF);
    end
    cyc(0, 0, 0, 0, 2, 2);
    expect_rd("sat_end", 32'h3000A, 32'h3000A, 32'h3000A, 32'h3000A, 32'h4, 16'hFFFF);
    cyc(0, 0, 0, 0, 2, 0);
    expect_rd("sat_idle", 32'h3000A, 0, 32'h3000A, 0, 0, 16'hFFFF);

    @(posedge inClk);
    @(posedge inClk);
    nchk++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
